// File: rtl/led_cmd_parser_pkg.sv
// rtl/led_cmd_parser_pkg.sv - shared constants, state encoding and checksum helper for led_cmd_parser
package led_cmd_parser_pkg;

    localparam logic [7:0] SYNC_WRITE = 8'hA5;
    localparam logic [7:0] SYNC_CLEAR = 8'hA6;
    localparam logic [7:0] CHK_SEED   = 8'h5A;
    localparam int         RGB_W      = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_COLOUR = 3'd2,
        ST_CHECK  = 3'd3,
        ST_CLEAR  = 3'd4
    } parser_state_t;

    function automatic logic [7:0] calc_chk(input logic [7:0] addr, input logic [7:0] colour);
        return addr ^ colour ^ CHK_SEED;
    endfunction

endpackage

// File: rtl/led_cmd_parser.sv
// rtl/led_cmd_parser.sv - UART byte-stream parser producing frame-buffer pixel writes and clear sweeps
module led_cmd_parser
    import led_cmd_parser_pkg::*;
#(
    parameter int ADDR_W  = 7,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_dv,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [RGB_W-1:0]  wr_rgb,
    output logic              busy,
    output logic [7:0]        err_count
);

    parser_state_t     state, state_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        col_q, col_d;
    logic [CNT_W-1:0]  tmo_cnt, tmo_d;
    logic [ADDR_W-1:0] clr_cnt, clr_d;
    logic              wr_en_d, busy_d, err_inc;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [RGB_W-1:0]  wr_rgb_d;
    logic              tmo_hit;

    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT));

    always_comb begin
        state_d   = state;
        addr_d    = addr_q;
        col_d     = col_q;
        tmo_d     = CNT_W'(0);
        clr_d     = clr_cnt;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_rgb_d  = wr_rgb;
        busy_d    = 1'b0;
        err_inc   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (rx_dv && rx_data == SYNC_WRITE) begin
                    state_d = ST_ADDR;
                end else if (rx_dv && rx_data == SYNC_CLEAR) begin
                    // Pixel 0 is written on the entry edge so busy and wr_en span the same 2^ADDR_W cycles
                    state_d   = ST_CLEAR;
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_W'(0);
                    wr_rgb_d  = RGB_W'(0);
                    clr_d     = ADDR_W'(1);
                    busy_d    = 1'b1;
                end
            end
            ST_ADDR, ST_COLOUR, ST_CHECK: begin
                if (rx_dv) begin
                    if (state == ST_ADDR) begin
                        addr_d  = rx_data;
                        state_d = ST_COLOUR;
                    end else if (state == ST_COLOUR) begin
                        col_d   = rx_data;
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_IDLE;
                        if (rx_data == calc_chk(addr_q, col_q)) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q[ADDR_W-1:0];
                            wr_rgb_d  = col_q[RGB_W-1:0];
                        end else begin
                            err_inc = 1'b1;
                        end
                    end
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                    err_inc = 1'b1;
                end else begin
                    tmo_d = tmo_cnt + CNT_W'(1);
                end
            end
            ST_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = clr_cnt;
                wr_rgb_d  = RGB_W'(0);
                busy_d    = 1'b1;
                clr_d     = clr_cnt + ADDR_W'(1);
                err_inc   = rx_dv;
                if (clr_cnt == {ADDR_W{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            addr_q    <= 8'h00;
            col_q     <= 8'h00;
            tmo_cnt   <= CNT_W'(0);
            clr_cnt   <= ADDR_W'(0);
            wr_en     <= 1'b0;
            wr_addr   <= ADDR_W'(0);
            wr_rgb    <= RGB_W'(0);
            busy      <= 1'b0;
            err_count <= 8'h00;
        end else begin
            state   <= state_d;
            addr_q  <= addr_d;
            col_q   <= col_d;
            tmo_cnt <= tmo_d;
            clr_cnt <= clr_d;
            wr_en   <= wr_en_d;
            wr_addr <= wr_addr_d;
            wr_rgb  <= wr_rgb_d;
            busy    <= busy_d;
            if (err_inc && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_led_cmd_parser.sv
// tb/tb_led_cmd_parser.sv - scoreboard bench for led_cmd_parser
module tb_led_cmd_parser;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_dv = 1'b0;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [2:0] wr_rgb;
    logic       busy;
    logic [7:0] err_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busy_cnt = 0;

    typedef struct {
        logic [6:0] addr;
        logic [2:0] rgb;
        int         cyc;
    } wr_t;
    wr_t exp_q[$];

    led_cmd_parser #(.ADDR_W(7), .TIMEOUT(1023), .CNT_W(10)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_dv(rx_dv),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_rgb(wr_rgb),
        .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", 32'(wr_addr), 32'hDEAD);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(wr_addr), 32'(e.addr));
                chk("write_rgb", 32'(wr_rgb), 32'(e.rgb));
                chk("write_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called at a negedge; holds rx_dv for one cycle then idles for gap cycles.
    task automatic send(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_dv = 1'b1;
        @(negedge clk);
        rx_dv = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [7:0] a, input logic [7:0] c, input logic [7:0] k, input int gap);
        send(8'hA5, gap);
        send(a, gap);
        send(c, gap);
        if (k == (a ^ c ^ 8'h5A)) begin
            wr_t e;
            e.addr = a[6:0];
            e.rgb = c[2:0];
            e.cyc = cyc + 1;
            exp_q.push_back(e);
        end
        send(k, gap);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_wr_en", 32'(wr_en), 0);
        chk("reset_wr_addr", 32'(wr_addr), 0);
        chk("reset_wr_rgb", 32'(wr_rgb), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_err", 32'(err_count), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        send_pkt(8'h23, 8'h05, 8'h7C, 3);
        chk("valid_err", 32'(err_count), 0);
        chk("valid_hold_addr", 32'(wr_addr), 32'h23);

        send_pkt(8'h23, 8'h05, 8'h7D, 3);
        chk("badchk_err", 32'(err_count), 1);
        send_pkt(8'h01, 8'h07, 8'h5C, 1);
        send_pkt(8'hA5, 8'hFE, 8'hA5 ^ 8'hFE ^ 8'h5A, 0);
        chk("upper_bits_err", 32'(err_count), 1);

        busy_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            wr_t e;
            e.addr = 7'(i);
            e.rgb = 3'b000;
            e.cyc = cyc + 1 + i;
            exp_q.push_back(e);
        end
        send(8'hA6, 49);
        chk("clear_busy_mid", 32'(busy), 1);
        send(8'h11, 0);
        repeat (90) @(negedge clk);
        chk("clear_busy_cycles", 32'(busy_cnt), 128);
        chk("clear_busy_done", 32'(busy), 0);
        chk("clear_err", 32'(err_count), 2);
        chk("clear_last_addr", 32'(wr_addr), 127);

        send(8'hA5, 1);
        send(8'h23, 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_rgb", 32'(wr_rgb), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_count), 0);
        send(8'h05, 1);
        send(8'h7C, 3);
        chk("rst_no_write_q", 32'(exp_q.size()), 0);
        chk("rst_err_after", 32'(err_count), 0);

        send(8'hA5, 0);
        send(8'h23, 990);
        chk("tmo_not_yet", 32'(err_count), 0);
        repeat (60) @(negedge clk);
        chk("tmo_err", 32'(err_count), 1);
        send(8'h05, 0);
        send(8'h7C, 3);
        chk("tmo_idle_err", 32'(err_count), 1);

        send_pkt(8'h10, 8'h02, 8'h10 ^ 8'h02 ^ 8'h5A, 0);
        send_pkt(8'h7F, 8'h04, 8'h7F ^ 8'h04 ^ 8'h5A, 0);
        repeat (2) @(negedge clk);
        chk("b2b_err", 32'(err_count), 1);

        for (int i = 0; i < 200; i++) send_pkt(8'(i), 8'h03, 8'(i) ^ 8'h03 ^ 8'h5A ^ 8'h01, 0);
        @(negedge clk);
        chk("sat_mid", 32'(err_count), 201);
        for (int i = 0; i < 100; i++) send_pkt(8'h44, 8'h01, 8'h00, 0);
        @(negedge clk);
        chk("sat_err", 32'(err_count), 255);

        repeat (3) @(negedge clk);
        chk("all_writes_seen", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_cmd_parser.md
Name: led_cmd_parser

Overview:
- Byte-stream command parser that consumes the UART receiver's byte output (uart_rx_data / uart_rx_dv pulse) inside the LED panel design.
- Turns validated packets into single-pixel write strobes for the panel frame buffer, or into a full-frame clear sweep.
- Sits between the UART receiver and the frame-buffer write port.
- Runs on the divided panel clock.

Parameters:
ADDR_W, 7, frame-buffer address width (128 pixels).
TIMEOUT, 1023, idle clock cycles allowed between bytes of one packet before it is abandoned.
CNT_W, 10, width of the inter-byte timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  panel clock.
reset  in  1  synchronous, active-low reset.
rx_data  in  8  received byte; valid only when rx_dv=1.
rx_dv  in  1  one-cycle strobe per received byte.
wr_en  out  1  one-cycle frame-buffer write strobe.
wr_addr  out  ADDR_W  pixel address qualified by wr_en.
wr_rgb  out  3  pixel colour {r,g,b} qualified by wr_en.
busy  out  1  high while a clear sweep is running.
err_count  out  8  saturating count of protocol errors.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, wr_en=0, wr_addr=0, wr_rgb=0, busy=0, err_count=0, timeout counter=0.
- Reset has priority over everything, including mid-packet and mid-clear; any partial packet is discarded with no write.
- Write packet format: 0xA5, ADDR, COLOUR, CHK, where CHK = ADDR ^ COLOUR ^ 0x5A.
  - Write uses ADDR[ADDR_W-1:0] and COLOUR[2:0].
  - Upper bits of ADDR and COLOUR are ignored for the write but included in the checksum.
- Clear command: the single byte 0xA6.
- States: IDLE, ADDR, COLOUR, CHECK, CLEAR.
- IDLE:
  - rx_dv with 0xA5 -> ADDR.
  - rx_dv with 0xA6 -> CLEAR.
  - Any other byte is silently ignored; no error is counted.
- ADDR: rx_dv latches the address byte -> COLOUR. Any value is accepted; a byte equal to 0xA5 is data, not a resync.
- COLOUR: rx_dv latches the colour byte -> CHECK.
- CHECK, on rx_dv:
  - Byte equals computed CHK -> wr_en=1 on the next cycle for exactly one cycle, with wr_addr/wr_rgb valid that cycle; -> IDLE.
  - Mismatch -> err_count+1, no write, -> IDLE.
- Latency: wr_en is registered and asserts one clk after the edge that samples the CHK byte's rx_dv.
- Back-to-back packets with no gap between bytes must all be accepted.
- Timeout (ADDR, COLOUR, CHECK only):
  - Counter clears on each rx_dv and on every state entry; it increments on every cycle without rx_dv.
  - When it reaches TIMEOUT: -> IDLE, err_count+1, no write.
  - If rx_dv arrives on that same cycle, the byte wins and the timeout does not fire.
- CLEAR:
  - busy=1 from the cycle after the 0xA6 strobe.
  - wr_en=1 with wr_rgb=0 for 2^ADDR_W consecutive cycles, wr_addr running 0,1,...,2^ADDR_W-1.
  - Then busy=0 and -> IDLE.
  - Any rx_dv during CLEAR drops the byte and adds 1 to err_count; the sweep is not interrupted.
- err_count saturates at 255 and never wraps.
- wr_addr/wr_rgb hold their last values when wr_en=0.

Decomposition:
- Shared package holds:
  - SYNC_WRITE=8'hA5, SYNC_CLEAR=8'hA6, CHK_SEED=8'h5A.
  - The state encoding typedef (IDLE..CLEAR).
  - The RGB field width of 3.
- Single module; the FSM, timeout counter and clear counter are small enough to be inlined, so no sub-module.

Test Plan:
- Valid write: A5,23,05,7C (gaps of 3 cycles) -> exactly one wr_en pulse, wr_addr=0x23, wr_rgb=3'b101, one cycle after the 7C strobe; err_count=0.
- Bad checksum: A5,23,05,7D -> no wr_en; err_count=1. A following valid packet A5,01,07,5C -> write addr 0x01, rgb 3'b111.
- Clear: A6 -> busy high 128 cycles; 128 consecutive wr_en pulses, addr 0..127, rgb 0. A byte injected at sweep cycle 50 -> err_count+1, sweep still completes at addr 127.
- Timeout: A5,23, then silence for 1023 cycles -> return to IDLE, err_count=1. Then 05,7C -> no write, since IDLE ignores both bytes.
- Reset mid-packet: A5,23, then reset=0 for one cycle, then 05,7C -> no write, err_count=0, all outputs at reset values.
- Back-to-back and saturation:
  - Two packets on consecutive-cycle rx_dv strobes -> two writes.
  - 300 bad-checksum packets -> err_count stops at 255.
